// File: rtl/pf_pkg.sv
// Shared definitions for the playfield RAM arbiter.
//   arb_state_t : arbiter operating mode (normal arbitration or hardware clear)
//   grant_t     : which requester owns the RAM port in the current cycle
//   DEF_ADDR_W / DEF_DATA_W : default RAM geometry (10x20 playfield, 4-bit tiles)
package pf_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 4;

  typedef enum logic {
    IDLE,
    CLEAR
  } arb_state_t;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_CPU,
    GNT_ENG,
    GNT_CLR
  } grant_t;

endpackage

// File: rtl/pf_ram_sp.sv
// Single-port synchronous playfield RAM with registered read data.
// Contents have no reset so the array maps onto a block RAM.
//   clk   : clock
//   we    : write enable for this cycle's access
//   addr  : access address
//   wdata : write data
//   rdata : data at addr, registered (valid the cycle after the access)
module pf_ram_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/playfield_ram_arbiter.sv
// Arbitrates the single-port playfield tile RAM between VGA scanout reads,
// Nios II Avalon-MM accesses and game-engine writes, and sequences a
// hardware clear of the whole playfield.
//   clk_clk, reset_reset_n             : system clock, async active-low reset
//   vga_rd_req/addr, vga_rd_data/valid : scanout read port (highest priority)
//   avs_*                              : Avalon-MM slave (read/write, waitrequest)
//   eng_valid/addr/wdata, eng_ready    : engine write port
//   clr_start, clr_busy, clr_done      : playfield clear control/status
module playfield_ram_arbiter
  import pf_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter int                DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic              vga_rd_valid,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  input  logic              eng_valid,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  arb_state_t        state;
  grant_t            grant;
  logic              last_eng;   // 1: engine was granted most recently
  logic [ADDR_W-1:0] clr_cnt;
  logic              cpu_req;
  logic              cpu_pend;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  assign cpu_req = avs_read | avs_write;

  // VGA always wins; in CLEAR the sequencer takes every remaining slot,
  // otherwise CPU and engine share by round-robin.
  always_comb begin
    grant = GNT_NONE;
    if (vga_rd_req)               grant = GNT_VGA;
    else if (state == CLEAR)      grant = GNT_CLR;
    else if (cpu_req && eng_valid) grant = last_eng ? GNT_CPU : GNT_ENG;
    else if (cpu_req)             grant = GNT_CPU;
    else if (eng_valid)           grant = GNT_ENG;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = vga_rd_addr;
    ram_wdata = CLR_VAL;
    case (grant)
      GNT_VGA: ram_addr = vga_rd_addr;
      GNT_CPU: begin
        ram_addr  = avs_address;
        ram_we    = avs_write;   // read+write together counts as a write
        ram_wdata = avs_writedata;
      end
      GNT_ENG: begin
        ram_addr  = eng_addr;
        ram_we    = 1'b1;
        ram_wdata = eng_wdata;
      end
      GNT_CLR: begin
        ram_addr  = clr_cnt;
        ram_we    = 1'b1;
        ram_wdata = CLR_VAL;
      end
      default: ;
    endcase
  end

  assign avs_waitrequest = cpu_req & (grant != GNT_CPU);
  assign eng_ready       = eng_valid & (grant == GNT_ENG);

  pf_ram_sp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk_clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );

  // RAM read data is unreset; gating by the registered valid keeps both
  // read-data outputs at zero out of reset and between pulses.
  assign vga_rd_data  = vga_rd_valid ? ram_q : '0;
  assign avs_readdata = avs_readdatavalid ? ram_q : '0;
  assign avs_readdatavalid = cpu_pend;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      clr_busy     <= 1'b0;
      clr_done     <= 1'b0;
      last_eng     <= 1'b1;
      vga_rd_valid <= 1'b0;
      cpu_pend     <= 1'b0;
    end else begin
      vga_rd_valid <= (grant == GNT_VGA);
      cpu_pend     <= (grant == GNT_CPU) && !avs_write;
      clr_done     <= 1'b0;

      if (grant == GNT_CPU)      last_eng <= 1'b0;
      else if (grant == GNT_ENG) last_eng <= 1'b1;

      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (grant == GNT_CLR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == '1) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/playfield_ram_arbiter.md
# playfield_ram_arbiter

Arbitrates a single-port on-chip playfield tile RAM among three requesters: VGA scanout reads, Nios II Avalon-MM accesses, and game-engine writes. It also sequences a hardware clear of the whole playfield. The block sits between the VGA text/tile renderer, the SoC's Avalon fabric and the Tetris engine logic, on the system clock.

## Interface
Parameters:
- ADDR_W, 8: RAM address width; depth = 2**ADDR_W (10x20 playfield fits in 256).
- DATA_W, 4: tile/colour index width.
- CLR_VAL, 0: value written to every cell by a clear.

Ports:
- clk_clk  in  1  system clock; all logic on rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- vga_rd_req  in  1  VGA read request.
- vga_rd_addr  in  ADDR_W  VGA read address.
- vga_rd_data  out  DATA_W  VGA read data.
- vga_rd_valid  out  1  vga_rd_data valid pulse.
- avs_address  in  ADDR_W  CPU word address.
- avs_read  in  1  CPU read strobe.
- avs_write  in  1  CPU write strobe.
- avs_writedata  in  DATA_W  CPU write data.
- avs_readdata  out  DATA_W  CPU read data.
- avs_readdatavalid  out  1  CPU read data valid.
- avs_waitrequest  out  1  CPU stall.
- eng_valid  in  1  engine write request.
- eng_addr  in  ADDR_W  engine write address.
- eng_wdata  in  DATA_W  engine write data.
- eng_ready  out  1  engine write accepted this cycle.
- clr_start  in  1  single-cycle clear request.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  single-cycle pulse when a clear finishes.

## Operation
- One RAM access per cycle, granted combinationally from current requests.
- Priority: VGA absolute. Then, in IDLE, CPU vs engine by round-robin. Then, in CLEAR, the clear sequencer.
- Round-robin: 1-bit pointer last_grant, updated only when CPU or engine is granted. On a tie the requester not granted last wins. Reset value favours CPU.
- avs_waitrequest = (avs_read | avs_write) & ~cpu_grant. eng_ready = eng_valid & eng_grant. Requesters hold address/data stable until accepted.
- avs_read and avs_write asserted together: treated as a write.
- FSM IDLE/CLEAR:
  - IDLE -> CLEAR on clr_start; clear counter loads 0.
  - CLEAR: CPU and engine are stalled (waitrequest/ready held inactive). In each cycle without a VGA request, write CLR_VAL at the counter address and increment.
  - After writing address 2**ADDR_W-1: go to IDLE and pulse clr_done for one cycle.
  - clr_start during CLEAR is ignored.
- VGA reads during CLEAR are served and return current contents, which may be partially cleared.
- Same-address writes from CPU and engine: serialized in grant order; the later write wins.
- Reset values: vga_rd_valid 0, avs_readdatavalid 0, vga_rd_data 0, avs_readdata 0, clr_busy 0, clr_done 0, FSM IDLE, counter 0, last_grant = engine (so CPU wins the first tie).
- Reset asserted mid-clear aborts the clear. RAM contents are not reset.

## Timing
- Granted read in cycle T: data and valid registered and presented in T+1; valid is a one-cycle pulse.
- Back-to-back granted reads give back-to-back valid pulses.
- Writes take effect at the granting edge; a read of that address granted in T+1 returns the new value.
- Clear takes exactly 2**ADDR_W cycles with no VGA traffic, plus one cycle per VGA-granted cycle during CLEAR.
- clr_busy is high from the cycle after clr_start through the cycle of the last clear write. clr_done is high in the following cycle.
- A VGA request held every cycle starves CPU, engine and clear indefinitely. This is by design; VGA asserts requests only during active video.

## Structure
- Shared package pf_pkg: arb_state_t enum {IDLE, CLEAR}, grant encoding (GNT_NONE, GNT_VGA, GNT_CPU, GNT_ENG, GNT_CLR), default widths.
- Sub-module pf_ram_sp: single-port synchronous RAM with registered read, inferable as M9K, no reset on contents.

## Test plan
- Reset, then VGA read of address 0x05 after a CPU write of 0x7 there: vga_rd_valid one cycle after grant, data 0x7; all outputs 0 during reset.
- CPU read and engine write requested together every cycle: grants alternate CPU, ENG, CPU, ...; CPU wins first; avs_waitrequest high exactly on engine cycles.
- VGA, CPU and engine all request: VGA granted; CPU waits; the next cycle without VGA serves CPU.
- clr_start with ADDR_W=4, no VGA: clr_busy high 16 cycles, clr_done pulse at cycle 17; all 16 cells read back 0. Engine eng_ready stays 0 throughout.
- clr_start during CLEAR plus VGA requests on 3 cycles: second start ignored; clear completes in 19 cycles.
- reset_reset_n asserted at clear address 8: FSM returns to IDLE and clr_busy drops immediately; no clr_done; addresses 8 and above keep their old values.
